// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the RV32I core: operand forwarding from MEM/WB,
// PC/immediate operand selection, load-use bubble insertion, flush and stall handling.
module id_ex_stage #(
    parameter int XLEN = 32,
    parameter int REGW = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [REGW-1:0] id_rs1,
    input  logic [REGW-1:0] id_rs2,
    input  logic            id_rs1_en,
    input  logic            id_rs2_en,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic            id_use_imm,
    input  logic [XLEN-1:0] id_pc,
    input  logic            id_use_pc,
    input  logic [3:0]      id_alu_fn,
    input  logic            id_btype,
    input  logic            id_bneq,
    input  logic [REGW-1:0] id_rd,
    input  logic            id_reg_we,
    input  logic            id_mem_rd,
    output logic            id_ready,
    input  logic            flush,
    input  logic            ex_stall,
    input  logic [REGW-1:0] mem_rd,
    input  logic            mem_reg_we,
    input  logic [XLEN-1:0] mem_result,
    input  logic [REGW-1:0] wb_rd,
    input  logic            wb_reg_we,
    input  logic [XLEN-1:0] wb_result,
    output logic            ex_valid,
    output logic [3:0]      ex_alu_fn,
    output logic            ex_btype,
    output logic            ex_bneq,
    output logic [XLEN-1:0] ex_operandA,
    output logic [XLEN-1:0] ex_operandB,
    output logic [XLEN-1:0] ex_store_data,
    output logic [XLEN-1:0] ex_pc,
    output logic [REGW-1:0] ex_rd,
    output logic            ex_reg_we,
    output logic            ex_mem_rd
);

    logic            valid_q,   valid_d;
    logic [3:0]      alu_fn_q,  alu_fn_d;
    logic            btype_q,   btype_d;
    logic            bneq_q,    bneq_d;
    logic            use_pc_q,  use_pc_d;
    logic            use_imm_q, use_imm_d;
    logic [XLEN-1:0] pc_q,      pc_d;
    logic [XLEN-1:0] imm_q,     imm_d;
    logic [REGW-1:0] rs1_q,     rs1_d;
    logic [REGW-1:0] rs2_q,     rs2_d;
    logic [XLEN-1:0] rs1_data_q, rs1_data_d;
    logic [XLEN-1:0] rs2_data_q, rs2_data_d;
    logic [REGW-1:0] rd_q,      rd_d;
    logic            reg_we_q,  reg_we_d;
    logic            mem_rd_q,  mem_rd_d;

    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;
    logic            hazard;

    // MEM is the younger producer, so it beats WB; x0 is never forwarded
    always_comb begin
        fwd_rs1 = rs1_data_q;
        if (mem_reg_we && (mem_rd != '0) && (mem_rd == rs1_q))
            fwd_rs1 = mem_result;
        else if (wb_reg_we && (wb_rd != '0) && (wb_rd == rs1_q))
            fwd_rs1 = wb_result;
    end

    always_comb begin
        fwd_rs2 = rs2_data_q;
        if (mem_reg_we && (mem_rd != '0) && (mem_rd == rs2_q))
            fwd_rs2 = mem_result;
        else if (wb_reg_we && (wb_rd != '0) && (wb_rd == rs2_q))
            fwd_rs2 = wb_result;
    end

    always_comb begin
        hazard = valid_q && mem_rd_q && (rd_q != '0) && id_valid &&
                 ((id_rs1_en && (id_rs1 == rd_q)) || (id_rs2_en && (id_rs2 == rd_q)));
    end

    assign id_ready = ~(hazard | ex_stall);

    always_comb begin
        valid_d    = valid_q;
        alu_fn_d   = alu_fn_q;
        btype_d    = btype_q;
        bneq_d     = bneq_q;
        use_pc_d   = use_pc_q;
        use_imm_d  = use_imm_q;
        pc_d       = pc_q;
        imm_d      = imm_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        rd_d       = rd_q;
        reg_we_d   = reg_we_q;
        mem_rd_d   = mem_rd_q;
        if (flush) begin
            valid_d  = 1'b0;
            alu_fn_d = 4'b0000;
            btype_d  = 1'b0;
            bneq_d   = 1'b0;
            reg_we_d = 1'b0;
            mem_rd_d = 1'b0;
        end else if (ex_stall) begin
            // refresh operands so a WB producer retiring during the stall is kept
            rs1_data_d = fwd_rs1;
            rs2_data_d = fwd_rs2;
        end else begin
            use_pc_d   = id_use_pc;
            use_imm_d  = id_use_imm;
            pc_d       = id_pc;
            imm_d      = id_imm;
            rs1_d      = id_rs1;
            rs2_d      = id_rs2;
            rs1_data_d = id_rs1_data;
            rs2_data_d = id_rs2_data;
            rd_d       = id_rd;
            if (hazard || !id_valid) begin
                valid_d  = 1'b0;
                alu_fn_d = 4'b0000;
                btype_d  = 1'b0;
                bneq_d   = 1'b0;
                reg_we_d = 1'b0;
                mem_rd_d = 1'b0;
            end else begin
                valid_d  = 1'b1;
                alu_fn_d = id_alu_fn;
                btype_d  = id_btype;
                bneq_d   = id_bneq;
                reg_we_d = id_reg_we;
                mem_rd_d = id_mem_rd;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            alu_fn_q   <= 4'b0000;
            btype_q    <= 1'b0;
            bneq_q     <= 1'b0;
            use_pc_q   <= 1'b0;
            use_imm_q  <= 1'b0;
            pc_q       <= '0;
            imm_q      <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            rd_q       <= '0;
            reg_we_q   <= 1'b0;
            mem_rd_q   <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            alu_fn_q   <= alu_fn_d;
            btype_q    <= btype_d;
            bneq_q     <= bneq_d;
            use_pc_q   <= use_pc_d;
            use_imm_q  <= use_imm_d;
            pc_q       <= pc_d;
            imm_q      <= imm_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            rd_q       <= rd_d;
            reg_we_q   <= reg_we_d;
            mem_rd_q   <= mem_rd_d;
        end
    end

    assign ex_valid      = valid_q;
    assign ex_alu_fn     = alu_fn_q;
    assign ex_btype      = btype_q;
    assign ex_bneq       = bneq_q;
    assign ex_operandA   = use_pc_q  ? pc_q  : fwd_rs1;
    assign ex_operandB   = use_imm_q ? imm_q : fwd_rs2;
    assign ex_store_data = fwd_rs2;
    assign ex_pc         = pc_q;
    assign ex_rd         = rd_q;
    assign ex_reg_we     = reg_we_q;
    assign ex_mem_rd     = mem_rd_q;

endmodule
